// File: rtl/mpcache_pkg.sv
// Shared sizing and state definitions for the block address arbiter.
package mpcache_pkg;

    localparam int unsigned NUM_PORTS      = 16;
    localparam int unsigned NUM_BLKS       = 256;
    localparam int unsigned BLK_WORDS      = 16;
    localparam int unsigned BLK_ADDR_WIDTH = $clog2(NUM_BLKS * BLK_WORDS);

    typedef enum logic {
        S_INIT,
        S_RUN
    } arb_state_e;

endpackage

// File: rtl/blk_free_fifo.sv
// Circular FIFO of free block indices; DEPTH must be a power of two so the
// pointers wrap on their own.
module blk_free_fifo #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/blk_addr_arb.sv
// Round-robin allocator handing out free SRAM block addresses to requesters,
// with the free list recycled from read-side releases.
module blk_addr_arb #(
    parameter int unsigned NUM_PORTS      = mpcache_pkg::NUM_PORTS,
    parameter int unsigned NUM_BLKS       = mpcache_pkg::NUM_BLKS,
    parameter int unsigned BLK_WORDS      = mpcache_pkg::BLK_WORDS,
    parameter int unsigned BLK_ADDR_WIDTH = $clog2(NUM_BLKS * BLK_WORDS)
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [NUM_PORTS-1:0]        i_addr_req,
    output logic [NUM_PORTS-1:0]        o_blk_addr_vld,
    output logic [BLK_ADDR_WIDTH-1:0]   o_blk_addr,
    input  logic                        i_free_vld,
    input  logic [BLK_ADDR_WIDTH-1:0]   i_free_addr,
    output logic [$clog2(NUM_BLKS):0]   o_free_cnt,
    output logic                        o_init_done,
    output logic [1:0]                  o_err
);

    import mpcache_pkg::*;

    localparam int unsigned IW  = $clog2(NUM_BLKS);
    localparam int unsigned OFF = $clog2(BLK_WORDS);
    localparam int unsigned PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    arb_state_e           state;
    logic [NUM_PORTS-1:0] pending;
    logic [PW-1:0]        rr_ptr;
    logic [IW-1:0]        init_idx;

    logic                 fifo_push;
    logic [IW-1:0]        fifo_push_data;
    logic                 fifo_pop;
    logic [IW-1:0]        fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;

    logic                 gnt_hit;
    logic [PW-1:0]        gnt_idx;
    logic [PW-1:0]        scan_idx;
    logic                 can_grant;
    logic [NUM_PORTS-1:0] grant_vec;
    logic [IW-1:0]        rel_idx;
    logic                 free_addr_unused;

    // Word-offset bits of a released address carry no block information.
    assign rel_idx          = i_free_addr[OFF +: IW];
    assign free_addr_unused = ^i_free_addr;

    always_comb begin
        gnt_hit  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            scan_idx = PW'((32'(rr_ptr) + k) % NUM_PORTS);
            if (!gnt_hit && pending[scan_idx]) begin
                gnt_hit = 1'b1;
                gnt_idx = scan_idx;
            end
        end
        can_grant = (state == S_RUN) && !fifo_empty && gnt_hit;
        grant_vec = can_grant ? (NUM_PORTS'(1) << gnt_idx) : '0;
    end

    // A release during init borrows the single push slot; the init walk stalls.
    always_comb begin
        fifo_pop       = can_grant;
        fifo_push      = ((state == S_INIT) || i_free_vld) && !fifo_full;
        fifo_push_data = ((state == S_RUN) || i_free_vld) ? rel_idx : init_idx;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= S_INIT;
            init_idx       <= '0;
            pending        <= '0;
            rr_ptr         <= '0;
            o_blk_addr_vld <= '0;
            o_blk_addr     <= '0;
            o_init_done    <= 1'b0;
            o_err          <= '0;
        end else begin
            // A fresh pulse on the port being granted re-arms its flag.
            pending <= (pending & ~grant_vec) | i_addr_req;
            if (|(i_addr_req & pending & ~grant_vec)) o_err[0] <= 1'b1;
            if (i_free_vld && fifo_full)               o_err[1] <= 1'b1;

            o_blk_addr_vld <= grant_vec;
            o_blk_addr     <= can_grant ? (BLK_ADDR_WIDTH'(fifo_head) << OFF) : '0;
            if (can_grant) begin
                rr_ptr <= (32'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + 1'b1;
            end

            case (state)
                S_INIT: begin
                    if (!i_free_vld) begin
                        init_idx <= init_idx + 1'b1;
                        if (init_idx == IW'(NUM_BLKS - 1)) begin
                            state       <= S_RUN;
                            o_init_done <= 1'b1;
                        end
                    end
                end
                S_RUN:   state <= S_RUN;
                default: state <= S_INIT;
            endcase
        end
    end

    blk_free_fifo #(
        .DEPTH (NUM_BLKS),
        .WIDTH (IW)
    ) u_free_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .count     (o_free_cnt),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_blk_addr_arb.sv
// Self-checking bench for blk_addr_arb: directed vectors, corner sequences and
// random traffic against a queue-based reference model.
module tb_blk_addr_arb;

    localparam int NP = 16;
    localparam int NB = 256;
    localparam int BW = 16;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NP-1:0] addr_req;
    logic [NP-1:0] blk_addr_vld;
    logic [AW-1:0] blk_addr;
    logic          free_vld;
    logic [AW-1:0] free_addr;
    logic [8:0]    free_cnt;
    logic          init_done;
    logic [1:0]    err;

    always #5 clk = ~clk;

    blk_addr_arb #(
        .NUM_PORTS      (NP),
        .NUM_BLKS       (NB),
        .BLK_WORDS      (BW),
        .BLK_ADDR_WIDTH (AW)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_addr_req     (addr_req),
        .o_blk_addr_vld (blk_addr_vld),
        .o_blk_addr     (blk_addr),
        .i_free_vld     (free_vld),
        .i_free_addr    (free_addr),
        .o_free_cnt     (free_cnt),
        .o_init_done    (init_done),
        .o_err          (err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: free list as a queue of block indices.
    int            fq[$];
    bit            pend[NP];
    int            rr;
    bit            m_done;
    int            m_icnt;
    logic [1:0]    m_err;
    logic [NP-1:0] m_vld;
    logic [AW-1:0] m_addr;

    typedef struct {
        logic [NP-1:0] req;
        logic          fv;
        logic [AW-1:0] fa;
        logic [NP-1:0] e_vld;
        logic [AW-1:0] e_addr;
        logic [8:0]    e_cnt;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        for (int p = 0; p < NP; p++) pend[p] = 1'b0;
        rr     = 0;
        m_done = 1'b0;
        m_icnt = 0;
        m_err  = '0;
        m_vld  = '0;
        m_addr = '0;
    endtask

    task automatic model_step(input logic [NP-1:0] req, input logic fv, input logic [AW-1:0] fa);
        int g;
        bit full;
        g    = -1;
        full = (fq.size() == NB);
        if (m_done && fq.size() > 0) begin
            for (int k = 0; k < NP; k++) begin
                if (g < 0 && pend[(rr + k) % NP]) g = (rr + k) % NP;
            end
        end
        for (int p = 0; p < NP; p++) begin
            if (req[p] && pend[p] && p != g) m_err[0] = 1'b1;
        end
        if (g >= 0) begin
            m_vld   = '0;
            m_vld[g] = 1'b1;
            m_addr  = AW'(fq.pop_front() * BW);
            pend[g] = 1'b0;
            rr      = (g + 1) % NP;
        end else begin
            m_vld  = '0;
            m_addr = '0;
        end
        for (int p = 0; p < NP; p++) begin
            if (req[p]) pend[p] = 1'b1;
        end
        if (fv) begin
            if (full) m_err[1] = 1'b1;
            else      fq.push_back(int'(fa) / BW);
        end else if (!m_done) begin
            if (!full) fq.push_back(m_icnt);
            m_icnt++;
            if (m_icnt == NB) m_done = 1'b1;
        end
    endtask

    task automatic cycle(input logic [NP-1:0] req, input logic fv, input logic [AW-1:0] fa);
        addr_req  = req;
        free_vld  = fv;
        free_addr = fa;
        @(posedge clk);
        model_step(req, fv, fa);
        #1;
        chk("vld",  32'(blk_addr_vld), 32'(m_vld));
        chk("addr", 32'(blk_addr),     32'(m_addr));
        chk("cnt",  32'(free_cnt),     32'(fq.size()));
        chk("done", 32'(init_done),    32'(m_done));
        chk("err",  32'(err),          32'(m_err));
        addr_req  = '0;
        free_vld  = 1'b0;
        free_addr = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_vld"},  32'(blk_addr_vld), 0);
        chk({tag, "_addr"}, 32'(blk_addr),     0);
        chk({tag, "_cnt"},  32'(free_cnt),     0);
        chk({tag, "_done"}, 32'(init_done),    0);
        chk({tag, "_err"},  32'(err),          0);
    endtask

    // Asserts reset between clock edges, checks the asynchronous clear, and
    // releases it just before a falling edge.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero(tag);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (!init_done && n < 400) begin
            cycle('0, 1'b0, '0);
            n++;
        end
        chk({tag, "_init_latency"}, 32'(n), 32'(NB));
        chk({tag, "_init_cnt"}, 32'(free_cnt), 32'(NB));
    endtask

    initial begin
        int n_gnt;
        int npend;
        int guard;
        logic [NP-1:0] r;

        rst_n     = 1'b0;
        addr_req  = '0;
        free_vld  = 1'b0;
        free_addr = '0;
        model_reset();
        #2;
        check_all_zero("reset");
        #21;
        rst_n = 1'b1;

        // Idle init: 256 cycles, full list, no grants.
        wait_init("idle");

        // Directed vectors straight after init (rr_ptr=0, head block 0).
        tbl[0] = '{16'h0008, 1'b0, 12'h000, 16'h0000, 12'h000, 9'd256};
        tbl[1] = '{16'h0000, 1'b0, 12'h000, 16'h0008, 12'h000, 9'd255};
        tbl[2] = '{16'h0003, 1'b0, 12'h000, 16'h0000, 12'h000, 9'd255};
        tbl[3] = '{16'h0000, 1'b0, 12'h000, 16'h0001, 12'h010, 9'd254};
        tbl[4] = '{16'h0000, 1'b0, 12'h000, 16'h0002, 12'h020, 9'd253};
        tbl[5] = '{16'h8000, 1'b1, 12'h00F, 16'h0000, 12'h000, 9'd254};
        tbl[6] = '{16'h0000, 1'b0, 12'h000, 16'h8000, 12'h030, 9'd253};
        tbl[7] = '{16'h0000, 1'b0, 12'h000, 16'h0000, 12'h000, 9'd253};
        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].req, tbl[i].fv, tbl[i].fa);
            chk($sformatf("tbl%0d_vld", i),  32'(blk_addr_vld), 32'(tbl[i].e_vld));
            chk($sformatf("tbl%0d_addr", i), 32'(blk_addr),     32'(tbl[i].e_addr));
            chk($sformatf("tbl%0d_cnt", i),  32'(free_cnt),     32'(tbl[i].e_cnt));
        end

        // Move rr_ptr to 5, then all ports request at once.
        cycle(16'h0010, 1'b0, '0);
        cycle('0, 1'b0, '0);
        chk("rr_setup_port4", 32'(blk_addr_vld), 32'h0010);
        chk("rr_setup_addr",  32'(blk_addr),     32'h040);
        cycle(16'hFFFF, 1'b0, '0);
        for (int i = 0; i < NP; i++) begin
            cycle('0, 1'b0, '0);
            chk($sformatf("rr_all_port_%0d", i), 32'(blk_addr_vld), 32'(1) << ((5 + i) % NP));
            chk($sformatf("rr_all_addr_%0d", i), 32'(blk_addr),     32'((5 + i) * BW));
        end

        // Drain to empty without leaving stray pending requests.
        guard = 0;
        while ((fq.size() > 0 || blk_addr_vld != '0) && guard < 600) begin
            npend = 0;
            for (int p = 0; p < NP; p++) npend += int'(pend[p]);
            r = '0;
            if (fq.size() > npend && !pend[guard % NP]) r[guard % NP] = 1'b1;
            cycle(r, 1'b0, '0);
            guard++;
        end
        for (int i = 0; i < 3; i++) cycle('0, 1'b0, '0);
        chk("drain_cnt", 32'(free_cnt), 0);
        cycle(16'h0080, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            cycle('0, 1'b0, '0);
            chk("starve_no_grant", 32'(blk_addr_vld), 0);
        end
        cycle('0, 1'b1, 12'h3A0);
        chk("release_no_bypass", 32'(blk_addr_vld), 0);
        cycle('0, 1'b0, '0);
        chk("release_grant_port", 32'(blk_addr_vld), 32'h0080);
        chk("release_grant_addr", 32'(blk_addr),     32'h3A0);
        chk("release_grant_cnt",  32'(free_cnt),     0);

        // Double request while pending, then overflowing release.
        do_reset("rst2");
        for (int i = 0; i < NB; i++) cycle((i == 10 || i == 20) ? 16'h0004 : 16'h0000, 1'b0, '0);
        chk("dup_done", 32'(init_done), 1);
        chk("dup_err0", 32'(err), 32'h1);
        n_gnt = 0;
        for (int i = 0; i < 6; i++) begin
            cycle('0, 1'b0, '0);
            if (blk_addr_vld == 16'h0004) n_gnt++;
        end
        chk("dup_one_grant", 32'(n_gnt), 1);
        chk("dup_cnt", 32'(free_cnt), 255);
        cycle('0, 1'b1, 12'h000);
        chk("refill_cnt", 32'(free_cnt), 256);
        cycle('0, 1'b1, 12'h050);
        chk("overflow_err", 32'(err), 32'h3);
        chk("overflow_cnt", 32'(free_cnt), 256);

        // Reset during init with latched requests and a sticky error.
        do_reset("rst3");
        for (int i = 0; i < 50; i++) begin
            case (i)
                5:       r = 16'h0002;
                6:       r = 16'h0012;
                7:       r = 16'h0200;
                8:       r = 16'h1000;
                default: r = '0;
            endcase
            cycle(r, 1'b0, '0);
        end
        chk("pre_rst_err", 32'(err), 32'h1);
        do_reset("midrst");
        n_gnt = 0;
        for (int i = 0; i < NB + 8; i++) begin
            cycle('0, 1'b0, '0);
            if (blk_addr_vld != '0) n_gnt++;
        end
        chk("midrst_no_grants", 32'(n_gnt), 0);
        chk("midrst_reinit", 32'(init_done), 1);

        // Random traffic: sparse requests, release rate low then high.
        for (int i = 0; i < 2000; i++) begin
            r = NP'($urandom & $urandom & $urandom);
            cycle(r, (i < 1000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                  AW'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
